falling_sprite_engine: RTL and testbench

FALLING_SPRITE_ENGINE -- requirements
Module: falling_sprite_engine

---
 rtl/falling_sprite_engine_pkg.sv | 32 +++
 rtl/falling_sprite_engine_sprite_channel.sv | 108 ++++++++++
 rtl/falling_sprite_engine.sv | 84 ++++++++
 tb/tb_falling_sprite_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/falling_sprite_engine_pkg.sv
// Shared types, colours and sprite geometry for the falling sprite engine.
// Geometry is done in signed 13-bit so offsets above/left of a sprite never wrap.
package falling_sprite_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALL    = 2'd1,
    ST_EXPLODE = 2'd2
  } sprite_state_t;

  localparam logic [5:0] COL_BODY = 6'b11_10_00;
  localparam logic [5:0] COL_LEAF = 6'b01_11_00;
  localparam logic [5:0] COL_FRAG = 6'b11_11_00;

  localparam logic signed [12:0] BODY_W    = 13'sd10;
  localparam logic signed [12:0] BODY_H    = 13'sd30;
  localparam logic signed [12:0] LEAF_XO   = 13'sd5;
  localparam logic signed [12:0] LEAF_W    = 13'sd20;
  localparam logic signed [12:0] LEAF_H    = 13'sd20;
  localparam logic signed [12:0] FRAG_SZ   = 13'sd5;
  localparam logic signed [12:0] FRAG_HALF = 13'sd2;
  localparam logic signed [12:0] FRAG_XO   = 13'sd5;
  localparam logic signed [12:0] FRAG_YO   = 13'sd15;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  function automatic logic in_rect(input logic signed [12:0] px, py, x0, y0, w, h);
    return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
  endfunction

endpackage

// File: rtl/falling_sprite_engine_sprite_channel.sv
// One sprite: IDLE/FALL/EXPLODE state, position, and combinational hit/colour.
// State moves only on launch or frame_tick; no backpressure.
module sprite_channel
  import falling_sprite_engine_pkg::*;
#(
  parameter int X_POS          = 160,
  parameter int Y_START        = 90,
  parameter int Y_FLOOR        = 290,
  parameter int SPEED          = 1,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic       busy,
  output logic       hit,
  output logic [5:0] rgb
);

  localparam logic [10:0] Y_START_L = 11'(Y_START);
  localparam logic [10:0] Y_FLOOR_L = 11'(Y_FLOOR);
  localparam logic [10:0] SPEED_L   = 11'(SPEED);
  localparam logic [5:0]  R_LAST    = 6'(EXPLODE_FRAMES - 1);
  localparam logic signed [12:0] XS = 13'(X_POS);
  localparam logic signed [12:0] CX = XS + FRAG_XO;
  localparam logic signed [12:0] CY = 13'(Y_FLOOR) + FRAG_YO;

  sprite_state_t state;
  logic [10:0]   y;
  logic [5:0]    r;
  logic [10:0]   y_step;

  assign y_step = y + SPEED_L;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      y     <= Y_START_L;
      r     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state <= ST_FALL;
            y     <= Y_START_L;
          end
        end
        ST_FALL: begin
          if (frame_tick) begin
            if (y == Y_FLOOR_L) begin
              state <= ST_EXPLODE;
              r     <= '0;
            end else if (y_step >= Y_FLOOR_L) begin
              y <= Y_FLOOR_L;
            end else begin
              y <= y_step;
            end
          end
        end
        ST_EXPLODE: begin
          if (frame_tick) begin
            if (r == R_LAST) begin
              state <= ST_IDLE;
              r     <= '0;
            end else begin
              r <= r + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  logic signed [12:0] px, py, ys, rs;
  logic on_screen, body_hit, leaf_hit, frag_hit;

  assign px = {3'b000, hpos};
  assign py = {3'b000, vpos};
  assign ys = {2'b00, y};
  assign rs = {7'b0000000, r};

  always_comb begin
    on_screen = (hpos < SCREEN_W) && (vpos < SCREEN_H);
    body_hit  = (state == ST_FALL) && in_rect(px, py, XS, ys, BODY_W, BODY_H);
    // Leaves occupy the LEAF_H rows directly above the body top edge.
    leaf_hit  = (state == ST_FALL) &&
                in_rect(px, py, XS - LEAF_XO, ys - LEAF_H, LEAF_W, LEAF_H);
    frag_hit  = (state == ST_EXPLODE) && (
                in_rect(px, py, CX - FRAG_SZ - rs, CY - FRAG_HALF, FRAG_SZ, FRAG_SZ) ||
                in_rect(px, py, CX + rs,           CY - FRAG_HALF, FRAG_SZ, FRAG_SZ) ||
                in_rect(px, py, CX - FRAG_HALF, CY - FRAG_SZ - rs, FRAG_SZ, FRAG_SZ) ||
                in_rect(px, py, CX - FRAG_HALF, CY + rs,           FRAG_SZ, FRAG_SZ));
    hit = on_screen && (body_hit || leaf_hit || frag_hit);
    rgb = '0;
    if (on_screen) begin
      if (body_hit)      rgb = COL_BODY;
      else if (leaf_hit) rgb = COL_LEAF;
      else if (frag_hit) rgb = COL_FRAG;
    end
  end

endmodule

// File: rtl/falling_sprite_engine.sv
// N independent falling sprites with lowest-index-wins pixel mux.
// Pixel outputs registered, 1 clk after hpos/vpos/display_on; no backpressure.
module falling_sprite_engine
  import falling_sprite_engine_pkg::*;
#(
  parameter int N_SPRITES      = 4,
  parameter int X_BASE         = 160,
  parameter int X_STEP         = 80,
  parameter int Y_START        = 90,
  parameter int Y_FLOOR        = 290,
  parameter int SPEED          = 1,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 display_on,
  input  logic                 frame_tick,
  input  logic [N_SPRITES-1:0] launch,
  output logic [N_SPRITES-1:0] busy,
  output logic [5:0]           rgb,
  output logic                 hit,
  output logic [2:0]           hit_id
);

  logic [N_SPRITES-1:0] ch_hit;
  logic [5:0]           ch_rgb [N_SPRITES];

  genvar gi;
  generate
    for (gi = 0; gi < N_SPRITES; gi++) begin : g_ch
      sprite_channel #(
        .X_POS          (X_BASE + gi * X_STEP),
        .Y_START        (Y_START),
        .Y_FLOOR        (Y_FLOOR),
        .SPEED          (SPEED),
        .EXPLODE_FRAMES (EXPLODE_FRAMES)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .launch     (launch[gi]),
        .hpos       (hpos),
        .vpos       (vpos),
        .busy       (busy[gi]),
        .hit        (ch_hit[gi]),
        .rgb        (ch_rgb[gi])
      );
    end
  endgenerate

  logic [5:0] win_rgb;
  logic [2:0] win_id;

  // Scan high to low so the lowest hitting index is the last one written.
  always_comb begin
    win_rgb = '0;
    win_id  = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (ch_hit[i]) begin
        win_rgb = ch_rgb[i];
        win_id  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb    <= '0;
      hit    <= 1'b0;
      hit_id <= '0;
    end else if (display_on && (|ch_hit)) begin
      rgb    <= win_rgb;
      hit    <= 1'b1;
      hit_id <= win_id;
    end else begin
      rgb    <= '0;
      hit    <= 1'b0;
      hit_id <= '0;
    end
  end

endmodule

// File: tb/tb_falling_sprite_engine.sv
// Directed bench: four engine instances (default, fast, overlapped, low start)
// share stimulus; each task checks its own hand-computed expectations.
module tb_falling_sprite_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       display_on = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] launch = '0;

  logic [3:0] busy_a, busy_s, busy_o, busy_y;
  logic [5:0] rgb_a, rgb_s, rgb_o, rgb_y;
  logic       hit_a, hit_s, hit_o, hit_y;
  logic [2:0] id_a, id_s, id_o, id_y;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  falling_sprite_engine dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_tick(frame_tick), .launch(launch), .busy(busy_a), .rgb(rgb_a),
    .hit(hit_a), .hit_id(id_a));

  falling_sprite_engine #(.SPEED(7)) dut_spd (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_tick(frame_tick), .launch(launch), .busy(busy_s), .rgb(rgb_s),
    .hit(hit_s), .hit_id(id_s));

  falling_sprite_engine #(.X_STEP(0)) dut_ovl (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_tick(frame_tick), .launch(launch), .busy(busy_o), .rgb(rgb_o),
    .hit(hit_o), .hit_id(id_o));

  falling_sprite_engine #(.Y_START(5)) dut_ys (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .frame_tick(frame_tick), .launch(launch), .busy(busy_y), .rgb(rgb_y),
    .hit(hit_y), .hit_id(id_y));

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; launch = '0; frame_tick = 1'b0; display_on = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse_launch(input logic [3:0] m);
    @(negedge clk); launch = m;
    @(negedge clk); launch = '0;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic probe(input int h, input int v);
    @(negedge clk); hpos = 10'(h); vpos = 10'(v); display_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({busy_a, busy_s, busy_o, busy_y} !== 16'h0) begin
      miscompares++; $display("FAIL reset_busy got=%h want=0", {busy_a, busy_s, busy_o, busy_y});
    end
    vectors++;
    if ({rgb_a, hit_a, id_a} !== 10'h0) begin
      miscompares++; $display("FAIL reset_pixel rgb=%b hit=%b id=%0d want 0", rgb_a, hit_a, id_a);
    end
    vectors++;
    if (dut.g_ch[0].u_ch.y !== 11'd90 || dut_ys.g_ch[0].u_ch.y !== 11'd5) begin
      miscompares++; $display("FAIL reset_y got=%0d/%0d want 90/5",
                              dut.g_ch[0].u_ch.y, dut_ys.g_ch[0].u_ch.y);
    end
    probe(162, 95);
    vectors++;
    if (hit_a !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle_nohit hit=%b want 0", hit_a);
    end
  endtask

  task automatic test_fall();
    do_reset();
    pulse_launch(4'b0001);
    vectors++;
    if (busy_a[0] !== 1'b1 || dut.g_ch[0].u_ch.y !== 11'd90) begin
      miscompares++; $display("FAIL fall_launch busy=%b y=%0d want 1/90", busy_a[0], dut.g_ch[0].u_ch.y);
    end
    for (int k = 1; k <= 200; k++) begin
      tick();
      vectors++;
      if (dut.g_ch[0].u_ch.y !== 11'(90 + k) || busy_a[0] !== 1'b1) begin
        miscompares++; $display("FAIL fall_y tick=%0d y=%0d busy=%b want y=%0d busy=1",
                                k, dut.g_ch[0].u_ch.y, busy_a[0], 90 + k);
      end
    end
    tick();  // 201: floor reached earlier, now explode with r=0
    probe(166, 304);
    vectors++;
    if (rgb_a !== 6'b111100 || hit_a !== 1'b1 || busy_a[0] !== 1'b1) begin
      miscompares++; $display("FAIL explode_r0 rgb=%b hit=%b busy=%b want 111100/1/1", rgb_a, hit_a, busy_a[0]);
    end
    for (int k = 202; k <= 216; k++) begin
      tick();
      vectors++;
      if (busy_a[0] !== 1'b1) begin
        miscompares++; $display("FAIL explode_busy tick=%0d busy=%b want 1", k, busy_a[0]);
      end
    end
    probe(181, 304);
    vectors++;
    if (rgb_a !== 6'b111100 || hit_a !== 1'b1) begin
      miscompares++; $display("FAIL explode_r15 rgb=%b hit=%b want 111100/1", rgb_a, hit_a);
    end
    probe(166, 304);
    vectors++;
    if (hit_a !== 1'b0) begin
      miscompares++; $display("FAIL explode_r15_moved hit=%b want 0", hit_a);
    end
    tick();  // 217: the tick seen with r=15 returns to idle
    vectors++;
    if (busy_a[0] !== 1'b0) begin
      miscompares++; $display("FAIL explode_done busy=%b want 0", busy_a[0]);
    end
  endtask

  task automatic test_speed_clamp();
    int exp_y;
    do_reset();
    pulse_launch(4'b0001);
    for (int k = 1; k <= 29; k++) begin
      tick();
      exp_y = (90 + 7 * k > 290) ? 290 : 90 + 7 * k;
      vectors++;
      if (dut_spd.g_ch[0].u_ch.y !== 11'(exp_y)) begin
        miscompares++; $display("FAIL speed_y tick=%0d y=%0d want %0d", k, dut_spd.g_ch[0].u_ch.y, exp_y);
      end
    end
    tick();
    probe(166, 304);
    vectors++;
    if (rgb_s !== 6'b111100 || busy_s[0] !== 1'b1) begin
      miscompares++; $display("FAIL speed_explode rgb=%b busy=%b want 111100/1", rgb_s, busy_s[0]);
    end
    do_reset();
    vectors++;
    if (busy_s[0] !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_explode busy=%b want 0", busy_s[0]);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    pulse_launch(4'b0010);
    for (int k = 0; k < 5; k++) tick();
    pulse_launch(4'b0001);   // sprite 0 at y=90, sprite 1 at y=95, same column
    probe(162, 92);
    vectors++;
    if (id_o !== 3'd0 || rgb_o !== 6'b111000 || hit_o !== 1'b1) begin
      miscompares++; $display("FAIL overlap_body id=%0d rgb=%b hit=%b want 0/111000/1", id_o, rgb_o, hit_o);
    end
    probe(162, 122);
    vectors++;
    if (id_o !== 3'd1 || rgb_o !== 6'b111000) begin
      miscompares++; $display("FAIL overlap_s1_body id=%0d rgb=%b want 1/111000", id_o, rgb_o);
    end
    probe(157, 80);
    vectors++;
    if (id_o !== 3'd0 || rgb_o !== 6'b011100) begin
      miscompares++; $display("FAIL overlap_leaf id=%0d rgb=%b want 0/011100", id_o, rgb_o);
    end
    probe(157, 92);
    vectors++;
    if (id_o !== 3'd1 || rgb_o !== 6'b011100) begin
      miscompares++; $display("FAIL overlap_s1_leaf id=%0d rgb=%b want 1/011100", id_o, rgb_o);
    end
  endtask

  task automatic test_pixel();
    do_reset();
    pulse_launch(4'b0101);
    probe(162, 95);
    vectors++;
    if (rgb_a !== 6'b111000 || hit_a !== 1'b1 || id_a !== 3'd0) begin
      miscompares++; $display("FAIL pixel_body rgb=%b hit=%b id=%0d want 111000/1/0", rgb_a, hit_a, id_a);
    end
    @(negedge clk); display_on = 1'b0;
    #2;
    vectors++;
    if (hit_a !== 1'b1) begin
      miscompares++; $display("FAIL pixel_latency hit=%b want 1 before edge", hit_a);
    end
    @(negedge clk);
    vectors++;
    if (rgb_a !== 6'b0 || hit_a !== 1'b0) begin
      miscompares++; $display("FAIL pixel_blank rgb=%b hit=%b want 0/0", rgb_a, hit_a);
    end
    probe(157, 80);
    vectors++;
    if (rgb_a !== 6'b011100 || hit_a !== 1'b1) begin
      miscompares++; $display("FAIL pixel_leaf rgb=%b hit=%b want 011100/1", rgb_a, hit_a);
    end
    probe(322, 95);
    vectors++;
    if (id_a !== 3'd2 || rgb_a !== 6'b111000) begin
      miscompares++; $display("FAIL pixel_s2 id=%0d rgb=%b want 2/111000", id_a, rgb_a);
    end
    @(negedge clk); display_on = 1'b0;
    @(negedge clk);
    vectors++;
    if (id_a !== 3'd0 || hit_a !== 1'b0) begin
      miscompares++; $display("FAIL pixel_s2_blank id=%0d hit=%b want 0/0", id_a, hit_a);
    end
  endtask

  task automatic test_reset_mid_fall();
    do_reset();
    pulse_launch(4'b0001);
    for (int k = 0; k < 50; k++) tick();
    pulse_launch(4'b0001);   // ignored while falling
    vectors++;
    if (dut.g_ch[0].u_ch.y !== 11'd140) begin
      miscompares++; $display("FAIL relaunch_ignored y=%0d want 140", dut.g_ch[0].u_ch.y);
    end
    @(negedge clk); reset = 1'b1; launch = 4'b0001;
    @(negedge clk);
    vectors++;
    if (busy_a[0] !== 1'b0 || dut.g_ch[0].u_ch.y !== 11'd90) begin
      miscompares++; $display("FAIL reset_mid_fall busy=%b y=%0d want 0/90", busy_a[0], dut.g_ch[0].u_ch.y);
    end
    reset = 1'b0; launch = '0;
    pulse_launch(4'b0001);
    tick();
    vectors++;
    if (busy_a[0] !== 1'b1 || dut.g_ch[0].u_ch.y !== 11'd91) begin
      miscompares++; $display("FAIL relaunch busy=%b y=%0d want 1/91", busy_a[0], dut.g_ch[0].u_ch.y);
    end
  endtask

  task automatic test_low_start();
    do_reset();
    @(negedge clk); launch = 4'b0001; frame_tick = 1'b1;
    @(negedge clk); launch = '0; frame_tick = 1'b0;
    vectors++;
    if (dut_ys.g_ch[0].u_ch.y !== 11'd5 || busy_y[0] !== 1'b1) begin
      miscompares++; $display("FAIL launch_with_tick y=%0d busy=%b want 5/1", dut_ys.g_ch[0].u_ch.y, busy_y[0]);
    end
    probe(157, 0);
    vectors++;
    if (rgb_y !== 6'b011100) begin
      miscompares++; $display("FAIL leaf_row0 rgb=%b want 011100", rgb_y);
    end
    probe(157, 4);
    vectors++;
    if (rgb_y !== 6'b011100) begin
      miscompares++; $display("FAIL leaf_row4 rgb=%b want 011100", rgb_y);
    end
    probe(157, 5);
    vectors++;
    if (hit_y !== 1'b0) begin
      miscompares++; $display("FAIL leaf_row5 hit=%b want 0", hit_y);
    end
    probe(162, 5);
    vectors++;
    if (rgb_y !== 6'b111000) begin
      miscompares++; $display("FAIL body_row5 rgb=%b want 111000", rgb_y);
    end
    probe(157, 1010);
    vectors++;
    if (hit_y !== 1'b0) begin
      miscompares++; $display("FAIL no_wrap hit=%b want 0", hit_y);
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_speed_clamp();
    test_overlap();
    test_pixel();
    test_reset_mid_fall();
    test_low_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
